// File: rtl/mixer_seq_ctrl.sv
// Command-queued sequencer for an array of two-input mixers.
// Each command runs fill-A, fill-B, mix and drain on one mixer's valve/pump lines.
module mixer_seq_ctrl #(
    parameter int N_MIX        = 70,
    parameter int IDX_W        = 7,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 8,
    parameter int FILL_CYCLES  = 16,
    parameter int MIX_CYCLES   = 64,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [IDX_W-1:0]              cmd_idx,
    input  logic [CNT_W-1:0]              cmd_mix,
    input  logic                          abort,
    output logic [N_MIX-1:0]              valve_a,
    output logic [N_MIX-1:0]              valve_b,
    output logic [N_MIX-1:0]              pump,
    output logic [N_MIX-1:0]              valve_y,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              done_idx,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_W-1:0] MIX_DEF  = CNT_W'(MIX_CYCLES);
    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FILL_A, FILL_B, MIX, DRAIN} state_t;

    logic [IDX_W-1:0]  fifo_idx [FIFO_DEPTH];
    logic [CNT_W-1:0]  fifo_mix [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_FW-1:0] count;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, mix_len, mix_len_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic              push, pop, head_bad, done_n, err_n;
    logic [N_MIX-1:0]  sel;

    function automatic logic [N_MIX-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_MIX-1:0] r;
        r = '0;
        for (int k = 0; k < N_MIX; k++) r[k] = (32'(i) == k);
        return r;
    endfunction

    assign cmd_ready  = (count != CNT_FW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign push       = cmd_valid && cmd_ready && !abort;
    // A push into an empty FIFO only becomes poppable once count has updated.
    assign pop        = (state == IDLE) && (count != '0) && !abort;
    assign head_bad   = 32'(fifo_idx[rd_ptr]) >= N_MIX;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr] <= cmd_idx;
            fifo_mix[wr_ptr] <= (cmd_mix == '0) ? MIX_DEF : cmd_mix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_FW'(1);
                2'b01:   count <= count - CNT_FW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mix_len <= '0;
            idx_q   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mix_len <= mix_len_n;
            idx_q   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mix_len_n = mix_len;
        idx_n     = idx_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        idx_n     = fifo_idx[rd_ptr];
                        mix_len_n = fifo_mix[rd_ptr];
                        cnt_n     = FILL_LD;
                        if (head_bad) err_n   = 1'b1;
                        else          state_n = FILL_A;
                    end
                end
                FILL_A: begin
                    if (cnt == '0) begin
                        state_n = FILL_B;
                        cnt_n   = FILL_LD;
                    end else cnt_n = cnt - CNT_W'(1);
                end
                FILL_B: begin
                    if (cnt == '0) begin
                        state_n = MIX;
                        cnt_n   = mix_len - CNT_W'(1);
                    end else cnt_n = cnt - CNT_W'(1);
                end
                MIX: begin
                    if (cnt == '0) begin
                        state_n = DRAIN;
                        cnt_n   = DRAIN_LD;
                    end else cnt_n = cnt - CNT_W'(1);
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else cnt_n = cnt - CNT_W'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Out-of-range indices decode to an all-zero select, so they never actuate.
    assign sel = onehot(idx_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valve_a  <= '0;
            valve_b  <= '0;
            pump     <= '0;
            valve_y  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_idx <= '0;
            err      <= 1'b0;
        end else begin
            valve_a  <= (state_n == FILL_A) ? sel : '0;
            valve_b  <= (state_n == FILL_B) ? sel : '0;
            pump     <= (state_n == MIX)    ? sel : '0;
            valve_y  <= (state_n == DRAIN)  ? sel : '0;
            busy     <= !abort && ((state != IDLE) || (count != '0));
            done     <= done_n;
            done_idx <= done_n ? idx_q : '0;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// Self-checking bench for mixer_seq_ctrl: directed table, corner-case sequences,
// and random traffic compared against a timeline model of each operation.
module tb_mixer_seq_ctrl;

    localparam int F = 16;
    localparam int M = 64;
    localparam int D = 16;
    localparam int NM = 70;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_idx = '0;
    logic [7:0]  cmd_mix = '0;
    logic        abort = 1'b0;
    logic [NM-1:0] valve_a, valve_b, pump, valve_y;
    logic        busy, done, err;
    logic [6:0]  done_idx;
    logic [3:0]  fifo_count;

    mixer_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_mix(cmd_mix), .abort(abort),
        .valve_a(valve_a), .valve_b(valve_b), .pump(pump), .valve_y(valve_y),
        .busy(busy), .done(done), .done_idx(done_idx), .err(err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: queue of pending commands plus the active operation,
    // located within its timeline by the number of cycles since FILL_A began.
    typedef struct packed { logic [6:0] idx; logic [7:0] len; } ent_t;
    ent_t mq[$];
    bit   m_act;
    int   m_el, m_idx, m_len;
    logic [NM-1:0] e_a, e_b, e_p, e_y;
    logic e_done, e_err, e_busy;
    int   e_didx, e_cnt;

    // Observations for directed sequences
    int obs_done_cyc, obs_err_cyc, obs_err_cnt, obs_pump, obs_a, obs_a_first;
    int obs_done_q[$];
    int obs_done_cq[$];

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_vectors();
        e_a = '0; e_b = '0; e_p = '0; e_y = '0;
        if (m_act) begin
            if (m_el < F)                e_a[m_idx] = 1'b1;
            else if (m_el < 2*F)         e_b[m_idx] = 1'b1;
            else if (m_el < 2*F + m_len) e_p[m_idx] = 1'b1;
            else                         e_y[m_idx] = 1'b1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_el = 0; m_idx = 0; m_len = 0;
        e_done = 0; e_err = 0; e_busy = 0; e_didx = 0; e_cnt = 0;
        model_vectors();
    endtask

    task automatic model_step(input logic v, input logic [6:0] i, input logic [7:0] m, input logic ab);
        int   sz;
        bit   was_act;
        ent_t ent;
        sz = mq.size();
        was_act = m_act;
        e_busy = !ab && (was_act || sz != 0);
        e_done = 0; e_err = 0; e_didx = 0;
        if (ab) begin
            mq.delete();
            m_act = 0;
        end else begin
            if (m_act) begin
                m_el++;
                if (m_el == 2*F + m_len + D) begin
                    m_act = 0; e_done = 1; e_didx = m_idx;
                end
            end
            if (!was_act && sz != 0) begin
                ent = mq.pop_front();
                if (ent.idx >= NM) e_err = 1;
                else begin
                    m_act = 1; m_el = 0; m_idx = ent.idx; m_len = ent.len;
                end
            end
            if (v && sz < 8) begin
                ent.idx = i;
                ent.len = (m == 0) ? 8'(M) : m;
                mq.push_back(ent);
            end
        end
        e_cnt = mq.size();
        model_vectors();
    endtask

    task automatic check_all();
        chk_vec("valve_a", 128'(valve_a), 128'(e_a));
        chk_vec("valve_b", 128'(valve_b), 128'(e_b));
        chk_vec("pump", 128'(pump), 128'(e_p));
        chk_vec("valve_y", 128'(valve_y), 128'(e_y));
        chk_int("done", int'(done), int'(e_done));
        if (e_done) chk_int("done_idx", int'(done_idx), e_didx);
        chk_int("err", int'(err), int'(e_err));
        chk_int("busy", int'(busy), int'(e_busy));
        chk_int("fifo_count", int'(fifo_count), e_cnt);
        chk_int("cmd_ready", int'(cmd_ready), int'(e_cnt < 8));
        chk_int("exclusive", int'($countones({valve_a, valve_b, pump, valve_y}) <= 1), 1);
    endtask

    task automatic clear_obs();
        obs_done_cyc = -1; obs_err_cyc = -1; obs_err_cnt = 0;
        obs_pump = 0; obs_a = 0; obs_a_first = -1;
        obs_done_q.delete();
        obs_done_cq.delete();
    endtask

    task automatic observe();
        if (done) begin
            if (obs_done_cyc < 0) obs_done_cyc = cyc;
            obs_done_q.push_back(int'(done_idx));
            obs_done_cq.push_back(cyc);
        end
        if (err) begin
            obs_err_cnt++;
            if (obs_err_cyc < 0) obs_err_cyc = cyc;
        end
        obs_pump += $countones(pump);
        obs_a    += $countones(valve_a);
        if (valve_a != '0 && obs_a_first < 0) obs_a_first = cyc;
    endtask

    task automatic tick(input logic v, input logic [6:0] i, input logic [7:0] m, input logic ab);
        cmd_valid = v; cmd_idx = i; cmd_mix = m; abort = ab;
        @(posedge clk);
        model_step(v, i, m, ab);
        cyc++;
        @(negedge clk);
        check_all();
        observe();
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 7'd0, 8'd0, 1'b0);
    endtask

    task automatic wait_model_idle(input string name, input int bound);
        int n;
        n = 0;
        while ((mq.size() != 0 || m_act) && n < bound) begin
            tick(1'b0, 7'd0, 8'd0, 1'b0);
            n++;
        end
        chk_int({name, "_idle_bound"}, int'(n < bound), 1);
        idle_ticks(2);
    endtask

    typedef struct {
        logic [6:0] idx;
        logic [7:0] mix;
        int         ev_off;   // done offset (valid) or err offset (invalid)
        int         pump_cyc;
        int         a_cyc;
        int         err_cnt;
    } vec_t;
    vec_t vt[6];

    int t0;

    task automatic run_one(input logic [6:0] i, input logic [7:0] m);
        int n;
        clear_obs();
        t0 = cyc;
        tick(1'b1, i, m, 1'b0);
        n = 0;
        while (obs_done_cyc < 0 && obs_err_cyc < 0 && n < 400) begin
            tick(1'b0, 7'd0, 8'd0, 1'b0);
            n++;
        end
        chk_int("run_one_bound", int'(n < 400), 1);
        idle_ticks(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{7'd5,   8'd0,   114, 64,  16, 0};
        vt[1] = '{7'd69,  8'd3,   53,  3,   16, 0};
        vt[2] = '{7'd0,   8'd1,   51,  1,   16, 0};
        vt[3] = '{7'd100, 8'd0,   2,   0,   0,  1};
        vt[4] = '{7'd33,  8'd255, 305, 255, 16, 0};
        vt[5] = '{7'd127, 8'd7,   2,   0,   0,  1};

        // Reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Directed table
        for (int k = 0; k < 6; k++) begin
            run_one(vt[k].idx, vt[k].mix);
            if (vt[k].err_cnt == 0) begin
                chk_int("tbl_done_off", obs_done_cyc - t0, vt[k].ev_off);
                chk_int("tbl_done_idx", obs_done_q.size() > 0 ? obs_done_q[0] : -1, int'(vt[k].idx));
                chk_int("tbl_first_fill", obs_a_first - t0, 2);
            end else begin
                chk_int("tbl_err_off", obs_err_cyc - t0, vt[k].ev_off);
                chk_int("tbl_no_done", obs_done_q.size(), 0);
            end
            chk_int("tbl_pump_cyc", obs_pump, vt[k].pump_cyc);
            chk_int("tbl_fill_a_cyc", obs_a, vt[k].a_cyc);
            chk_int("tbl_err_cnt", obs_err_cnt, vt[k].err_cnt);
        end

        // Fill the FIFO while an operation runs; the tenth offer must be ignored
        clear_obs();
        tick(1'b1, 7'd10, 8'd1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) begin
                chk_int("full_count", int'(fifo_count), 8);
                chk_int("full_ready", int'(cmd_ready), 0);
            end
            tick(1'b1, 7'(10 + k), 8'd1, 1'b0);
        end
        begin
            int n;
            n = 0;
            while (obs_done_q.size() < 9 && n < 1000) begin
                tick(1'b0, 7'd0, 8'd0, 1'b0);
                n++;
            end
            chk_int("full_bound", int'(n < 1000), 1);
        end
        idle_ticks(60);
        chk_int("full_done_cnt", obs_done_q.size(), 9);
        for (int k = 0; k < 9 && k < obs_done_q.size(); k++)
            chk_int("full_order", obs_done_q[k], 10 + k);
        if (obs_done_cq.size() >= 2)
            chk_int("full_gap", obs_done_cq[1] - obs_done_cq[0], 2*F + 1 + D + 1);

        // Invalid index sandwiched between two valid ones
        clear_obs();
        tick(1'b1, 7'd1, 8'd1, 1'b0);
        tick(1'b1, 7'd100, 8'd0, 1'b0);
        tick(1'b1, 7'd2, 8'd1, 1'b0);
        wait_model_idle("inv", 400);
        chk_int("inv_err_cnt", obs_err_cnt, 1);
        chk_int("inv_done_cnt", obs_done_q.size(), 2);
        if (obs_done_q.size() == 2) begin
            chk_int("inv_first", obs_done_q[0], 1);
            chk_int("inv_second", obs_done_q[1], 2);
        end

        // Abort during MIX with three entries queued
        tick(1'b1, 7'd7, 8'd50, 1'b0);
        tick(1'b1, 7'd8, 8'd0, 1'b0);
        tick(1'b1, 7'd9, 8'd0, 1'b0);
        tick(1'b1, 7'd10, 8'd0, 1'b0);
        chk_int("abort_queued", int'(fifo_count), 3);
        begin
            int n;
            n = 0;
            while (!pump[7] && n < 100) begin
                tick(1'b0, 7'd0, 8'd0, 1'b0);
                n++;
            end
            chk_int("abort_mix_bound", int'(n < 100), 1);
        end
        clear_obs();
        tick(1'b0, 7'd0, 8'd0, 1'b1);
        chk_vec("abort_vectors", 128'({valve_a, valve_b, pump, valve_y} != '0), 128'(0));
        chk_int("abort_count", int'(fifo_count), 0);
        chk_int("abort_busy", int'(busy), 0);
        idle_ticks(150);
        chk_int("abort_no_done", obs_done_q.size(), 0);
        chk_int("abort_no_err", obs_err_cnt, 0);

        // Asynchronous reset in the middle of FILL_B
        tick(1'b1, 7'd3, 8'd0, 1'b0);
        begin
            int n;
            n = 0;
            while (!valve_b[3] && n < 100) begin
                tick(1'b0, 7'd0, 8'd0, 1'b0);
                n++;
            end
            chk_int("rst_fillb_bound", int'(n < 100), 1);
        end
        rst = 1'b1;
        #1;
        chk_vec("rst_async_valve_b", 128'(valve_b), 128'(0));
        chk_vec("rst_async_all", 128'({valve_a, valve_b, pump, valve_y} != '0), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc++;
        check_all();
        run_one(7'd3, 8'd0);
        chk_int("rst_rerun_done_off", obs_done_cyc - t0, 2 + 2*F + M + D);
        chk_int("rst_rerun_pump", obs_pump, M);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic       v, ab;
            logic [6:0] i;
            logic [7:0] m;
            v  = ($urandom_range(0, 3) == 0);
            i  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(70, 127)) : 7'($urandom_range(0, 69));
            m  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            ab = ($urandom_range(0, 199) == 0);
            tick(v, i, m, ab);
        end
        wait_model_idle("rand", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mixer_seq_ctrl.md
# mixer_seq_ctrl

Parametrised sequencer for an array of `N_MIX` two-input mixers, such as a cubic-graph mixer network. It buffers mixer-operation commands in a FIFO and runs each one through the phases fill-A, fill-B, mix and drain. During each phase it drives the matching valve or pump line of the addressed mixer. It sits between the assay scheduler, which issues commands in topological order, and the valve/pump driver bank of the fabricated chip.

## Interface
- `N_MIX`, 70: number of mixers controlled.
- `IDX_W`, 7: mixer index width; must satisfy 2^IDX_W ≥ N_MIX.
- `FIFO_DEPTH`, 8: command FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: phase counter width.
- `FILL_CYCLES`, 16: cycles per fill phase; range 1..2^CNT_W-1.
- `MIX_CYCLES`, 64: default mix cycles; range 1..2^CNT_W-1.
- `DRAIN_CYCLES`, 16: cycles in the drain phase; range 1..2^CNT_W-1.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_idx` in IDX_W: target mixer.
- `cmd_mix` in CNT_W: mix-time override; 0 selects `MIX_CYCLES`.
- `abort` in 1: flush and stop.
- `valve_a` out N_MIX: inlet-a valve, one bit per mixer.
- `valve_b` out N_MIX: inlet-b valve, one bit per mixer.
- `pump` out N_MIX: mixing pump enable, one bit per mixer.
- `valve_y` out N_MIX: outlet valve, one bit per mixer.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `done` out 1: one-cycle pulse when an operation completes.
- `done_idx` out IDX_W: index of the completed mixer; valid while `done` is high.
- `err` out 1: one-cycle pulse when an out-of-range index is dropped.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push rule: a command is pushed when `cmd_valid && cmd_ready`. The pushed entry is {idx, effective mix length}; a `cmd_mix` of 0 is resolved to `MIX_CYCLES` at push time.
- FSM states: IDLE, FILL_A, FILL_B, MIX, DRAIN.
- IDLE with FIFO non-empty:
  - Pop the head entry, latch idx and mix length, load the counter.
  - If idx ≥ N_MIX: pulse `err` next cycle, stay IDLE, no actuation.
  - Otherwise go to FILL_A.
- Phase durations and outputs:
  - FILL_A lasts FILL_CYCLES cycles; only `valve_a[idx]` is high.
  - FILL_B lasts FILL_CYCLES cycles; only `valve_b[idx]` is high.
  - MIX lasts the latched mix length; only `pump[idx]` is high.
  - DRAIN lasts DRAIN_CYCLES cycles; only `valve_y[idx]` is high.
- Completion: after the last DRAIN cycle, go to IDLE and assert `done` with `done_idx` = idx in that IDLE cycle. That same IDLE cycle may pop the next entry.
- Mutual exclusion: at most one bit across all four output vectors is high in any cycle. All four vectors are registered outputs.
- Simultaneous push and pop: `fifo_count` is unchanged. A push to an empty FIFO is not visible to the pop until the next cycle.
- Full FIFO: `cmd_ready` = 0. `cmd_valid` is ignored and nothing is overwritten. After a pop, `cmd_ready` returns high in the following cycle.
- Read/write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the count.
- `abort` is sampled each cycle and has priority over push, pop and phase advance:
  - FIFO is emptied; a push in the same cycle is discarded.
  - FSM goes to IDLE.
  - All outputs go to 0 on the next edge.
  - No `done` or `err` is generated for the aborted operation.
- Reset (`rst` high): FSM = IDLE, FIFO empty, counters = 0. All vectors, `done`, `err` and `busy` = 0, `done_idx` = 0, `fifo_count` = 0, `cmd_ready` = 1. Asserting reset mid-phase closes every valve immediately (asynchronously).

## Timing
- Accept at cycle t into an idle, empty block:
  - t+1: pop.
  - t+2 .. t+1+F: FILL_A.
  - Next F cycles: FILL_B.
  - Next M cycles: MIX.
  - Next D cycles: DRAIN.
  - `done` at cycle t+2+2F+M+D.
- Back-to-back commands: exactly one IDLE cycle between the DRAIN of one command and the FILL_A of the next.
- An invalid entry consumes one IDLE cycle. `err` is high in the cycle after the pop.
- `busy` is registered and goes low the cycle after IDLE is reached with an empty FIFO.

## Test plan
- Reset, then single command idx=5, `cmd_mix`=0 at cycle t:
  - `valve_a[5]` high for t+2..t+17.
  - `valve_b[5]` high for t+18..t+33.
  - `pump[5]` high for t+34..t+97.
  - `valve_y[5]` high for t+98..t+113.
  - `done` pulses with `done_idx`=5 at t+114.
- Override: idx=69, `cmd_mix`=3 → `pump[69]` high for exactly 3 cycles; `done` at t+53.
- Fill to 8 entries during a running op → `cmd_ready`=0, `fifo_count`=8. The 9th `cmd_valid` is ignored. Completions arrive in FIFO order with one IDLE gap each.
- Invalid idx=100 queued between idx 1 and idx 2 → `err` pulses once, no output bit rises for it, idx 2 still completes.
- `abort` during MIX with 3 entries queued → all outputs 0 next cycle, `fifo_count`=0, `busy` falls, no `done`.
- `rst` asserted mid-FILL_B → `valve_b` drops without waiting for a clock edge. After release, a new command runs a full sequence.
